// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer: register address
// widths, entry layout and head/tail pointer types.
package reorder_buffer_pkg;

  localparam int REG_ADDR_WIDTH  = 5;
  localparam int ROB_WIDTH       = 3;
  localparam int PREG_ADDR_WIDTH = REG_ADDR_WIDTH + 1;
  localparam int ROB_DEPTH       = 1 << ROB_WIDTH;

  typedef logic [REG_ADDR_WIDTH-1:0]  vreg_t;
  typedef logic [PREG_ADDR_WIDTH-1:0] preg_t;

  // Entry index (addresses the array) and pointer (index plus wrap bit).
  typedef logic [ROB_WIDTH-1:0] rob_index_t;
  typedef logic [ROB_WIDTH:0]   rob_ptr_t;

  typedef struct packed {
    logic  valid;
    logic  done;
    vreg_t virtual_rd;
    preg_t physical_rd;
    preg_t old_physical_rd;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of allocate / complete / commit / flush signals between the
// pipeline (master) and the reorder buffer (slave).
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic       alloc_valid;
  logic       alloc_ready;
  vreg_t      alloc_virtual_rd;
  preg_t      alloc_physical_rd;
  preg_t      alloc_old_physical_rd;
  rob_index_t alloc_index;

  logic       complete_valid;
  rob_index_t complete_index;

  logic       commit_ready;
  logic       commit_valid;
  vreg_t      commit_virtual_rd;
  preg_t      commit_physical_rd;
  preg_t      commit_old_physical_rd;

  logic       flush;
  rob_ptr_t   count;
  logic       empty;
  logic       full;

  modport master (
    output alloc_valid, alloc_virtual_rd, alloc_physical_rd, alloc_old_physical_rd,
    output complete_valid, complete_index, commit_ready, flush,
    input  alloc_ready, alloc_index, commit_valid, commit_virtual_rd,
    input  commit_physical_rd, commit_old_physical_rd, count, empty, full
  );

  modport slave (
    input  alloc_valid, alloc_virtual_rd, alloc_physical_rd, alloc_old_physical_rd,
    input  complete_valid, complete_index, commit_ready, flush,
    output alloc_ready, alloc_index, commit_valid, commit_virtual_rd,
    output commit_physical_rd, commit_old_physical_rd, count, empty, full
  );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement tracker. Entries are allocated at the tail in program
// order, marked done by writeback, and retired from the head, returning the
// previous physical mapping to the free list. Flush discards everything.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  reorder_buffer_if.slave bus
);

  rob_entry_t entries [ROB_DEPTH];
  rob_ptr_t   head;
  rob_ptr_t   tail;
  rob_index_t head_idx;
  rob_index_t tail_idx;
  rob_entry_t head_entry;
  logic       full_w;
  logic       alloc_fire;
  logic       commit_valid_w;
  logic       commit_fire;

  assign head_idx   = head[ROB_WIDTH-1:0];
  assign tail_idx   = tail[ROB_WIDTH-1:0];
  assign head_entry = entries[head_idx];

  // Same index with opposite wrap bits means the tail has lapped the head.
  assign full_w = (head[ROB_WIDTH] != tail[ROB_WIDTH]) && (head_idx == tail_idx);

  // Ready comes from registered state only, so a slot freed by a commit this
  // cycle cannot be reused until the next one. Flush overrides everything.
  assign alloc_fire     = bus.alloc_valid && !full_w && !bus.flush;
  assign commit_valid_w = head_entry.valid && head_entry.done && !bus.flush;
  assign commit_fire    = commit_valid_w && bus.commit_ready;

  assign bus.alloc_ready            = !full_w;
  assign bus.alloc_index            = tail_idx;
  assign bus.commit_valid           = commit_valid_w;
  assign bus.commit_virtual_rd      = head_entry.valid ? head_entry.virtual_rd      : '0;
  assign bus.commit_physical_rd     = head_entry.valid ? head_entry.physical_rd     : '0;
  assign bus.commit_old_physical_rd = head_entry.valid ? head_entry.old_physical_rd : '0;
  assign bus.count                  = tail - head;
  assign bus.empty                  = (head == tail);
  assign bus.full                   = full_w;

  // Pointer and entry state: allocate at tail, mark done, retire at head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      // NOTE: the entry array is a small flop array, so every field gets the
      // async reset; this keeps the whole block a plain reset-flop group.
      for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
    end else if (bus.flush) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
    end else begin
      if (alloc_fire) begin
        entries[tail_idx] <= '{valid:           1'b1,
                               done:            1'b0,
                               virtual_rd:      bus.alloc_virtual_rd,
                               physical_rd:     bus.alloc_physical_rd,
                               old_physical_rd: bus.alloc_old_physical_rd};
        tail <= tail + rob_ptr_t'(1);
      end
      // Only already-valid entries can complete; an entry being allocated
      // this cycle still reads as invalid here.
      if (bus.complete_valid && entries[bus.complete_index].valid) begin
        entries[bus.complete_index].done <= 1'b1;
      end
      // NOTE: the retire clear is written last so that, among non-blocking
      // updates to the same entry this cycle, the clear wins.
      if (commit_fire) begin
        entries[head_idx].valid <= 1'b0;
        entries[head_idx].done  <= 1'b0;
        head <= head + rob_ptr_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer: reset, in-order allocation,
// out-of-order completion with in-order retire, full/wrap, commit
// backpressure, flush priority, ignored completions and async reset.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  reorder_buffer_if bus ();

  reorder_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input int vrd, input int prd, input int old);
    bus.alloc_valid           = 1'b1;
    bus.alloc_virtual_rd      = vreg_t'(vrd);
    bus.alloc_physical_rd     = preg_t'(prd);
    bus.alloc_old_physical_rd = preg_t'(old);
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic do_complete(input int idx);
    bus.complete_valid = 1'b1;
    bus.complete_index = rob_index_t'(idx);
    tick();
    bus.complete_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.alloc_virtual_rd = '0;
    bus.alloc_physical_rd = '0;
    bus.alloc_old_physical_rd = '0;
    bus.complete_valid = 1'b0;
    bus.complete_index = '0;
    bus.commit_ready = 1'b0;
    bus.flush = 1'b0;
    repeat (2) tick();
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %b expected 1", bus.alloc_ready); end
    checks++; if (bus.alloc_index !== 3'd0) begin errors++; $display("FAIL reset_alloc_index: got %0d expected 0", bus.alloc_index); end
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid: got %b expected 0", bus.commit_valid); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b expected empty=1 full=0", bus.empty, bus.full); end
    checks++; if (bus.commit_old_physical_rd !== 6'd0) begin errors++; $display("FAIL reset_commit_data: got %0d expected 0", bus.commit_old_physical_rd); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alloc();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.alloc_index !== rob_index_t'(i)) begin errors++; $display("FAIL alloc_index_%0d: got %0d expected %0d", i, bus.alloc_index, i); end
      do_alloc(i + 1, 32 + i, i + 1);
    end
    checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL alloc_count: got %0d expected 3", bus.count); end
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL alloc_no_commit: got %b expected 0", bus.commit_valid); end
  endtask

  task automatic test_complete_order();
    do_complete(1);
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_no_commit: got %b expected 0", bus.commit_valid); end
    do_complete(0);
    checks++; if (bus.commit_valid !== 1'b1 || bus.commit_old_physical_rd !== 6'd1 || bus.commit_physical_rd !== 6'd32 || bus.commit_virtual_rd !== 5'd1)
      begin errors++; $display("FAIL retire_first: got v=%b vrd=%0d prd=%0d old=%0d expected v=1 vrd=1 prd=32 old=1", bus.commit_valid, bus.commit_virtual_rd, bus.commit_physical_rd, bus.commit_old_physical_rd); end
    bus.commit_ready = 1'b1;
    tick();
    checks++; if (bus.commit_valid !== 1'b1 || bus.commit_old_physical_rd !== 6'd2) begin errors++; $display("FAIL retire_second: got v=%b old=%0d expected v=1 old=2", bus.commit_valid, bus.commit_old_physical_rd); end
    tick();
    bus.commit_ready = 1'b0;
    checks++; if (bus.commit_valid !== 1'b0 || bus.count !== 4'd1 || bus.commit_virtual_rd !== 5'd3)
      begin errors++; $display("FAIL entry2_stays: got v=%b count=%0d vrd=%0d expected v=0 count=1 vrd=3", bus.commit_valid, bus.count, bus.commit_virtual_rd); end
  endtask

  task automatic test_full_wrap();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.alloc_index !== rob_index_t'(i)) begin errors++; $display("FAIL fill_index_%0d: got %0d expected %0d", i, bus.alloc_index, i); end
      do_alloc(i + 1, 40 + i, 10 + i);
    end
    checks++; if (bus.full !== 1'b1 || bus.alloc_ready !== 1'b0 || bus.count !== 4'd8)
      begin errors++; $display("FAIL full_flags: got full=%b ready=%b count=%0d expected full=1 ready=0 count=8", bus.full, bus.alloc_ready, bus.count); end
    do_complete(0);
    bus.commit_ready = 1'b1;
    bus.alloc_valid = 1'b1;
    bus.alloc_virtual_rd = 5'd9;
    bus.alloc_physical_rd = 6'd48;
    bus.alloc_old_physical_rd = 6'd18;
    checks++; if (bus.alloc_ready !== 1'b0 || bus.commit_valid !== 1'b1) begin errors++; $display("FAIL full_commit_cycle: got ready=%b commit=%b expected ready=0 commit=1", bus.alloc_ready, bus.commit_valid); end
    tick();
    bus.commit_ready = 1'b0;
    checks++; if (bus.count !== 4'd7 || bus.alloc_ready !== 1'b1 || bus.alloc_index !== 3'd0)
      begin errors++; $display("FAIL freed_slot: got count=%0d ready=%b index=%0d expected count=7 ready=1 index=0", bus.count, bus.alloc_ready, bus.alloc_index); end
    tick();
    bus.alloc_valid = 1'b0;
    checks++; if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.alloc_index !== 3'd1 || bus.commit_old_physical_rd !== 6'd11)
      begin errors++; $display("FAIL wrap_alloc: got count=%0d full=%b index=%0d old=%0d expected count=8 full=1 index=1 old=11", bus.count, bus.full, bus.alloc_index, bus.commit_old_physical_rd); end
  endtask

  task automatic test_commit_backpressure();
    do_complete(1);
    do_complete(2);
    do_complete(3);
    tick();
    checks++; if (bus.commit_valid !== 1'b1 || bus.count !== 4'd8 || bus.commit_old_physical_rd !== 6'd11)
      begin errors++; $display("FAIL held_head: got v=%b count=%0d old=%0d expected v=1 count=8 old=11", bus.commit_valid, bus.count, bus.commit_old_physical_rd); end
    bus.commit_ready = 1'b1;
    tick();
    checks++; if (bus.count !== 4'd7 || bus.commit_old_physical_rd !== 6'd12) begin errors++; $display("FAIL one_retire_a: got count=%0d old=%0d expected count=7 old=12", bus.count, bus.commit_old_physical_rd); end
    tick();
    checks++; if (bus.count !== 4'd6 || bus.commit_old_physical_rd !== 6'd13) begin errors++; $display("FAIL one_retire_b: got count=%0d old=%0d expected count=6 old=13", bus.count, bus.commit_old_physical_rd); end
    tick();
    bus.commit_ready = 1'b0;
    checks++; if (bus.count !== 4'd5 || bus.commit_valid !== 1'b0) begin errors++; $display("FAIL retire_stop: got count=%0d v=%b expected count=5 v=0", bus.count, bus.commit_valid); end
  endtask

  task automatic test_flush();
    do_complete(4);
    checks++; if (bus.commit_valid !== 1'b1 || bus.count !== 4'd5) begin errors++; $display("FAIL pre_flush: got v=%b count=%0d expected v=1 count=5", bus.commit_valid, bus.count); end
    bus.flush = 1'b1;
    bus.commit_ready = 1'b1;
    bus.alloc_valid = 1'b1;
    bus.alloc_virtual_rd = 5'd7;
    bus.alloc_physical_rd = 6'd60;
    bus.alloc_old_physical_rd = 6'd30;
    #1;
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL flush_gates_commit: got %b expected 0", bus.commit_valid); end
    tick();
    bus.flush = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.commit_ready = 1'b0;
    checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.alloc_index !== 3'd0 || bus.alloc_ready !== 1'b1)
      begin errors++; $display("FAIL post_flush: got count=%0d empty=%b index=%0d ready=%b expected count=0 empty=1 index=0 ready=1", bus.count, bus.empty, bus.alloc_index, bus.alloc_ready); end
  endtask

  task automatic test_ignored_complete();
    do_complete(0);
    do_alloc(5, 50, 20);
    bus.complete_valid = 1'b1;
    bus.complete_index = 3'd1;
    do_alloc(6, 51, 21);
    bus.complete_valid = 1'b0;
    do_complete(0);
    checks++; if (bus.commit_valid !== 1'b1 || bus.commit_old_physical_rd !== 6'd20 || bus.count !== 4'd2)
      begin errors++; $display("FAIL stale_complete: got v=%b old=%0d count=%0d expected v=1 old=20 count=2", bus.commit_valid, bus.commit_old_physical_rd, bus.count); end
    bus.commit_ready = 1'b1;
    tick();
    bus.commit_ready = 1'b0;
    checks++; if (bus.commit_valid !== 1'b0 || bus.commit_old_physical_rd !== 6'd21)
      begin errors++; $display("FAIL same_cycle_complete: got v=%b old=%0d expected v=0 old=21", bus.commit_valid, bus.commit_old_physical_rd); end
  endtask

  task automatic test_async_reset();
    do_complete(1);
    do_alloc(8, 52, 22);
    do_alloc(9, 53, 23);
    do_alloc(10, 54, 24);
    checks++; if (bus.count !== 4'd4 || bus.commit_valid !== 1'b1) begin errors++; $display("FAIL pre_reset: got count=%0d v=%b expected count=4 v=1", bus.count, bus.commit_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.commit_valid !== 1'b0 || bus.alloc_index !== 3'd0 || bus.commit_old_physical_rd !== 6'd0 || bus.alloc_ready !== 1'b1)
      begin errors++; $display("FAIL async_reset: got count=%0d empty=%b v=%b index=%0d old=%0d ready=%b expected 0/1/0/0/0/1", bus.count, bus.empty, bus.commit_valid, bus.alloc_index, bus.commit_old_physical_rd, bus.alloc_ready); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_alloc();
    test_complete_order();
    test_full_wrap();
    test_commit_backpressure();
    test_flush();
    test_ignored_complete();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
